seq_mult_unit: RTL
==================

Name: seq_mult_unit

Overview:
- Parametrised sequential multiplier: controller FSM and datapath in one block, the next generation of the team's start/done load-and-accumulate controllers.
- Radix-2 shift-add on operand magnitudes, one multiplier bit per cycle.
- Early termination once the remaining multiplier bits are zero.
- Optional signed (two's-complement) operation.
- Sits between a register-mapped operand interface and any consumer of the product.

Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.
- SIGNED_EN, 1, 1 = signed_op input honoured; 0 = signed_op ignored, always unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge of clk only when busy=0.
- signed_op  input  1  1 = treat a, b as two's complement; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress (CALC, FIX).
- done  output  1  one-cycle pulse: product valid.
- product  output  2*WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, product=0; all internal registers cleared. Reset mid-operation aborts it; no done is produced.
- States: IDLE, CALC, FIX, DONE.
  - busy=1 only in CALC and FIX.
  - done=1 only in DONE.
- Start acceptance: start=1 at an edge in IDLE or DONE, which gives back-to-back issue. At that edge:
  - Capture mag_a=|a|, mag_b=|b|, neg = signed_op & SIGNED_EN & (a[MSB]^b[MSB]).
  - Clear the accumulator (2*WIDTH) and the shift index.
  - Clear product to 0.
- Magnitudes in signed mode: the magnitude of the most-negative value (-2^(WIDTH-1)) is 2^(WIDTH-1) and fits unsigned in WIDTH bits. In unsigned mode magnitude = raw value.
- Zero shortcut: if mag_a==0 or mag_b==0 at acceptance, go directly to FIX. The result is 0 with no sign fix (never "negative zero").
- Otherwise go to CALC.
- CALC, each edge:
  - If mag_b[0], accumulator += mag_a << index (2*WIDTH arithmetic, no overflow possible).
  - Then mag_b >>= 1 and index++.
  - If the shifted mag_b==0, go to FIX; else stay in CALC.
  - Number of CALC cycles k = position of highest set bit of mag_b + 1 (1..WIDTH).
- FIX, one edge: product <= neg ? -accumulator (two's complement, 2*WIDTH bits) : accumulator. Go to DONE.
- DONE, one cycle: done=1. Next edge: to CALC/FIX if start=1, else to IDLE.
- Latency: done goes high k+1 edges after the accepting edge (k=0 for the zero shortcut), for exactly one cycle.
- start while busy=1 is ignored; operands are not re-sampled.
- a, b and signed_op may change freely after acceptance without effect.
- product changes only at the accepting edge (cleared) and at the FIX edge.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then WIDTH=8, unsigned, a=13, b=11, start one cycle -> busy high for 5 cycles; done pulse 5 edges after acceptance (k=4); product=143 (0x008F); busy=0 in the done cycle.
- Signed, a=-3 (0xFD), b=5 -> k=3; done 4 edges after acceptance; product=0xFFF1 (-15). Same operands with SIGNED_EN=0 -> product=253*5=1265 (0x04F1).
- Signed corner, a=b=0x80 (-128) -> k=8; product=0x4000. Unsigned a=b=0xFF -> product=0xFE01, k=8.
- Zero shortcut: a=0, b=200 (and a=-7, b=0 signed) -> done 1 edge after acceptance; product=0x0000.
- Protocol checks:
  - start held high throughout -> back-to-back operations accepted in the DONE cycle.
  - start pulses during busy are ignored.
  - Changing a/b during CALC does not alter the result.
- Async reset: assert rst_n=0 mid-CALC between edges -> busy, done and product go to 0 immediately. After release, a new start (6*7) completes normally with product=42.

Source files
------------

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add sequential multiplier with early termination and optional
// two's-complement operation; start/done handshake, product held until next start.
module seq_mult_unit #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic [IW-1:0]    r_idx;

  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_zero;
  logic [WIDTH-1:0] w_mag_b_shr;
  logic [PW-1:0]    w_addend;

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_signed    = SIGNED_EN & signed_op;
  assign w_a_neg     = w_signed & a[WIDTH-1];
  assign w_b_neg     = w_signed & b[WIDTH-1];
  // Negating the most-negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_mag_a     = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_mag_b     = w_b_neg ? (~b + WIDTH'(1)) : b;
  assign w_zero      = (w_mag_a == '0) || (w_mag_b == '0);
  assign w_mag_b_shr = r_mag_b >> 1;
  assign w_addend    = {{WIDTH{1'b0}}, r_mag_a} << r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_zero ? S_FIX : S_CALC;
      S_CALC: if (w_mag_b_shr == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        if (w_accept) w_next = w_zero ? S_FIX : S_CALC;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mag_a   <= w_mag_a;
      r_mag_b   <= w_mag_b;
      r_neg     <= ~w_zero & (w_a_neg ^ w_b_neg);
      r_acc     <= '0;
      r_idx     <= '0;
      r_product <= '0;
    end else if (r_state == S_CALC) begin
      if (r_mag_b[0]) r_acc <= r_acc + w_addend;
      r_mag_b <= w_mag_b_shr;
      r_idx   <= r_idx + IW'(1);
    end else if (r_state == S_FIX) begin
      r_product <= r_neg ? (~r_acc + PW'(1)) : r_acc;
    end
  end

  assign busy    = (r_state == S_CALC) || (r_state == S_FIX);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
